// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC sample DMA block.
// Holds the DMA FSM state encoding and the word-address helper.
package adc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } dma_state_t;

    localparam int ADC_DATA_W = 12;
    localparam int WORD_BYTES = 4;
    localparam int TS_W       = 20;

    // Word-aligned ring address: the low two base bits are ignored.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return {base[31:2], 2'b00} + (idx * WORD_BYTES);
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous sample FIFO with flush; a push while full is accepted
// when a pop happens in the same cycle.
module adc_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/adc_sample_dma.sv
// ADC sample DMA: buffers 12-bit samples and writes them as 32-bit words into a RAM ring.
// Optional ADC_DMA_TIMESTAMP_EN stores a 20-bit sample counter in the upper word bits.
module adc_sample_dma
    import adc_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = ADC_DATA_W,
    parameter int LEN_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_en,
    input  logic              cfg_clear,
    input  logic [31:0]       cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic [LEN_W-1:0]  wr_index,
    output logic              ovf,
    output logic              irq_half,
    output logic              irq_wrap
);

`ifdef ADC_DMA_TIMESTAMP_EN
    localparam int ENTRY_W = TS_W + DATA_W;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    dma_state_t         state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [LEN_W-1:0]   cur_idx_q, cur_idx_d;
    logic [LEN_W-1:0]   wr_index_q, wr_index_d;
    logic               ovf_q, ovf_d;
    logic               irq_half_q, irq_half_d;
    logic               irq_wrap_q, irq_wrap_d;
    logic               clr_pend_q, clr_pend_d;

    logic               len_nz;
    logic [LEN_W-1:0]   len_last;
    logic [LEN_W-1:0]   len_half;
    logic [LEN_W-1:0]   idx_eff;
    logic               do_clear;
    logic               push;
    logic               start;
    logic               done;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;

`ifdef ADC_DMA_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;

    always_comb begin
        ts_cnt_d = ts_cnt_q;
        if (cfg_clear) begin
            ts_cnt_d = '0;
        end else if (s_valid) begin
            ts_cnt_d = ts_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
        end
    end

    assign fifo_wdata = {ts_cnt_q, s_data};
`else
    assign fifo_wdata = s_data;
`endif

    // A clear raised mid-transfer waits for the handshake so mem_valid never drops early.
    always_comb begin
        len_nz   = (cfg_len != '0);
        len_last = cfg_len - 1'b1;
        len_half = cfg_len >> 1;
        idx_eff  = (wr_index_q >= cfg_len) ? '0 : wr_index_q;
        done     = (state_q == ST_REQ) && mem_ready;
        do_clear = (cfg_clear || clr_pend_q) && ((state_q == ST_IDLE) || mem_ready);
        push     = s_valid && cfg_en && len_nz && !do_clear;
        start    = (state_q == ST_IDLE) && !fifo_empty && cfg_en && len_nz && !do_clear;
    end

    adc_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (do_clear),
        .push  (push),
        .pop   (start),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ;
            ST_REQ:  if (mem_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_valid = (state_q == ST_REQ);
        mem_wstrb = mem_valid ? 4'hF : 4'h0;
        mem_addr  = addr_q;
        mem_wdata = data_q;
        wr_index  = wr_index_q;
        ovf       = ovf_q;
        irq_half  = irq_half_q;
        irq_wrap  = irq_wrap_q;
    end

    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        cur_idx_d  = cur_idx_q;
        wr_index_d = wr_index_q;
        ovf_d      = ovf_q;
        irq_half_d = 1'b0;
        irq_wrap_d = 1'b0;
        clr_pend_d = clr_pend_q;
        if (start) begin
            addr_d    = word_addr(cfg_base, 32'(idx_eff));
            data_d    = 32'(fifo_rdata);
            cur_idx_d = idx_eff;
        end
        if (done) begin
            wr_index_d = (cur_idx_q >= len_last) ? '0 : cur_idx_q + 1'b1;
            irq_wrap_d = len_nz && (cur_idx_q == len_last);
            irq_half_d = len_nz && (cfg_len != LEN_W'(1)) && (cur_idx_q == len_half);
        end
        if (push && fifo_full && !start) begin
            ovf_d = 1'b1;
        end
        if (cfg_clear && (state_q == ST_REQ) && !mem_ready) begin
            clr_pend_d = 1'b1;
        end
        if (do_clear) begin
            ovf_d      = 1'b0;
            wr_index_d = '0;
            clr_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            data_q     <= '0;
            cur_idx_q  <= '0;
            wr_index_q <= '0;
            ovf_q      <= 1'b0;
            irq_half_q <= 1'b0;
            irq_wrap_q <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            cur_idx_q  <= cur_idx_d;
            wr_index_q <= wr_index_d;
            ovf_q      <= ovf_d;
            irq_half_q <= irq_half_d;
            irq_wrap_q <= irq_wrap_d;
            clr_pend_q <= clr_pend_d;
        end
    end

endmodule

// File: tb/tb_adc_sample_dma.sv
// Directed bench for adc_sample_dma: ring writes, irqs, overflow, enable/clear/reset boundaries.
// Build with ADC_DMA_TIMESTAMP_EN to expect counter bits in the upper data word.
module tb_adc_sample_dma;

    logic        clk;
    logic        reset;
    logic        cfg_en;
    logic        cfg_clear;
    logic [31:0] cfg_base;
    logic [15:0] cfg_len;
    logic        s_valid;
    logic [11:0] s_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [15:0] wr_index;
    logic        ovf;
    logic        irq_half;
    logic        irq_wrap;

    int checks;
    int failures;
    int ready_delay;
    int wait_cnt;
    int half_cnt;
    int wrap_cnt;
    logic [31:0] half_addr;
    logic [31:0] wrap_addr;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [19:0] ts_ctr;

    adc_sample_dma dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_en    (cfg_en),
        .cfg_clear (cfg_clear),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .wr_index  (wr_index),
        .ovf       (ovf),
        .irq_half  (irq_half),
        .irq_wrap  (irq_wrap)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus responder: accepts after ready_delay waiting cycles and logs each accepted write.
    always @(posedge clk) begin
        #1;
        mem_ready = 1'b0;
        if (mem_valid) begin
            if (wait_cnt >= ready_delay) begin
                mem_ready = 1'b1;
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (irq_half) begin
            half_cnt++;
            if (wr_addr_q.size() > 0) half_addr = wr_addr_q[wr_addr_q.size()-1];
        end
        if (irq_wrap) begin
            wrap_cnt++;
            if (wr_addr_q.size() > 0) wrap_addr = wr_addr_q[wr_addr_q.size()-1];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_sample(input logic [11:0] v);
        s_valid = 1'b1;
        s_data  = v;
        step();
        s_valid = 1'b0;
        ts_ctr  = ts_ctr + 20'd1;
    endtask

    task automatic pulse_clear();
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        ts_ctr    = '0;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        half_cnt  = 0;
        wrap_cnt  = 0;
        half_addr = '0;
        wrap_addr = '0;
    endtask

    function automatic logic [31:0] word_of(input logic [11:0] v, input logic [19:0] ts);
`ifdef ADC_DMA_TIMESTAMP_EN
        return {ts, v};
`else
        return {20'd0, v} | (32'(ts) & 32'd0);
`endif
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset  = 1'b0;
        ts_ctr = '0;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
        checks++; if (mem_wstrb !== 4'h0) begin failures++; $display("FAIL reset_wstrb got=%h exp=0", mem_wstrb); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
        checks++; if (wr_index !== 16'd0) begin failures++; $display("FAIL reset_wr_index got=%0d exp=0", wr_index); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if ({irq_half, irq_wrap} !== 2'b00) begin failures++; $display("FAIL reset_irq got=%b exp=00", {irq_half, irq_wrap}); end
    endtask

    task automatic test_ring();
        logic [11:0] smp [4];
        logic [31:0] exp_a [4];
        logic [19:0] t0;
        smp   = '{12'd2500, 12'd1000, 12'd2000, 12'd3000};
        exp_a = '{32'h400, 32'h404, 32'h408, 32'h40C};
        clear_logs();
        cfg_base = 32'h400; cfg_len = 16'd4; cfg_en = 1'b1; ready_delay = 1;
        t0 = ts_ctr;
        for (int i = 0; i < 4; i++) send_sample(smp[i]);
        for (int i = 0; i < 100 && wr_addr_q.size() < 4; i++) step();
        repeat (3) step();
        checks++; if (wr_addr_q.size() !== 4) begin failures++; $display("FAIL ring_count got=%0d exp=4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== exp_a[i]) begin failures++; $display("FAIL ring_addr%0d got=%h exp=%h", i, wr_addr_q[i], exp_a[i]); end
            checks++; if (wr_data_q[i] !== word_of(smp[i], t0 + 20'(i))) begin failures++; $display("FAIL ring_data%0d got=%h exp=%h", i, wr_data_q[i], word_of(smp[i], t0 + 20'(i))); end
        end
        checks++; if (half_cnt !== 1 || half_addr !== 32'h408) begin failures++; $display("FAIL ring_irq_half cnt=%0d addr=%h exp=1/408", half_cnt, half_addr); end
        checks++; if (wrap_cnt !== 1 || wrap_addr !== 32'h40C) begin failures++; $display("FAIL ring_irq_wrap cnt=%0d addr=%h exp=1/40c", wrap_cnt, wrap_addr); end
        checks++; if (wr_index !== 16'd0) begin failures++; $display("FAIL ring_wr_index got=%0d exp=0", wr_index); end
    endtask

    task automatic test_fifth_sample();
        logic [19:0] t0;
        clear_logs();
        t0 = ts_ctr;
        send_sample(12'd123);
        for (int i = 0; i < 50 && wr_addr_q.size() < 1; i++) step();
        repeat (2) step();
        checks++; if (wr_addr_q.size() !== 1) begin failures++; $display("FAIL fifth_count got=%0d exp=1", wr_addr_q.size()); end
        if (wr_addr_q.size() > 0) begin
            checks++; if (wr_addr_q[0] !== 32'h400) begin failures++; $display("FAIL fifth_addr got=%h exp=400", wr_addr_q[0]); end
            checks++; if (wr_data_q[0] !== word_of(12'd123, t0)) begin failures++; $display("FAIL fifth_data got=%h exp=%h", wr_data_q[0], word_of(12'd123, t0)); end
        end
        checks++; if (wr_index !== 16'd1) begin failures++; $display("FAIL fifth_wr_index got=%0d exp=1", wr_index); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_a [9];
        logic [19:0] t0;
        int bad;
        exp_a = '{32'h404, 32'h408, 32'h40C, 32'h400, 32'h404, 32'h408, 32'h40C, 32'h400, 32'h404};
        clear_logs();
        ready_delay = 1000;
        t0 = ts_ctr;
        for (int i = 0; i < 10; i++) send_sample(12'(100 + i));
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h404 || mem_wdata !== word_of(12'd100, t0) || mem_wstrb !== 4'hF) begin
                failures++;
                if (bad < 3) $display("FAIL ovf_hold cyc=%0d valid=%b addr=%h data=%h strb=%h exp=1/404/%h/f", i, mem_valid, mem_addr, mem_wdata, mem_wstrb, word_of(12'd100, t0));
                bad++;
            end
            step();
        end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        ready_delay = 1;
        for (int i = 0; i < 200 && wr_addr_q.size() < 9; i++) step();
        repeat (10) step();
        checks++; if (wr_addr_q.size() !== 9) begin failures++; $display("FAIL ovf_count got=%0d exp=9", wr_addr_q.size()); end
        for (int i = 0; i < 9 && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== word_of(12'(100 + i), t0 + 20'(i))) begin
                failures++; $display("FAIL ovf_write%0d got=%h/%h exp=%h/%h", i, wr_addr_q[i], wr_data_q[i], exp_a[i], word_of(12'(100 + i), t0 + 20'(i)));
            end
        end
        checks++; if (wr_index !== 16'd2) begin failures++; $display("FAIL ovf_wr_index got=%0d exp=2", wr_index); end
        pulse_clear();
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
        checks++; if (wr_index !== 16'd0) begin failures++; $display("FAIL clear_wr_index got=%0d exp=0", wr_index); end
    endtask

    task automatic test_disable_in_req();
        logic [19:0] t0;
        int seen;
        clear_logs();
        ready_delay = 3;
        t0 = ts_ctr;
        send_sample(12'd700);
        for (int i = 0; i < 20 && mem_valid !== 1'b1; i++) step();
        checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL dis_req_start got=%b exp=1", mem_valid); end
        cfg_en = 1'b0;
        send_sample(12'd500);
        send_sample(12'd600);
        for (int i = 0; i < 20 && wr_addr_q.size() < 1; i++) step();
        step();
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (mem_valid === 1'b1) seen++;
            step();
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL dis_no_valid got=%0d exp=0", seen); end
        cfg_en = 1'b1;
        repeat (8) step();
        checks++; if (wr_addr_q.size() !== 1) begin failures++; $display("FAIL dis_count got=%0d exp=1", wr_addr_q.size()); end
        if (wr_addr_q.size() > 0) begin
            checks++; if (wr_addr_q[0] !== 32'h400 || wr_data_q[0] !== word_of(12'd700, t0)) begin
                failures++; $display("FAIL dis_write got=%h/%h exp=400/%h", wr_addr_q[0], wr_data_q[0], word_of(12'd700, t0));
            end
        end
        checks++; if (wr_index !== 16'd1) begin failures++; $display("FAIL dis_wr_index got=%0d exp=1", wr_index); end
    endtask

    task automatic test_len0_and_reset();
        clear_logs();
        cfg_len = 16'd0;
        for (int i = 0; i < 3; i++) send_sample(12'(40 + i));
        repeat (10) step();
        checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("FAIL len0_writes got=%0d exp=0", wr_addr_q.size()); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL len0_ovf got=%b exp=0", ovf); end
        cfg_len = 16'd4;
        ready_delay = 1000;
        send_sample(12'd55);
        for (int i = 0; i < 20 && mem_valid !== 1'b1; i++) step();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h404) begin failures++; $display("FAIL rst_req valid=%b addr=%h exp=1/404", mem_valid, mem_addr); end
        reset = 1'b1;
        step();
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rst_drop_valid got=%b exp=0", mem_valid); end
        checks++; if (wr_index !== 16'd0) begin failures++; $display("FAIL rst_wr_index got=%0d exp=0", wr_index); end
        reset  = 1'b0;
        ts_ctr = '0;
        ready_delay = 1;
        repeat (5) step();
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rst_fifo_empty got=%b exp=0", mem_valid); end
    endtask

    task automatic test_len1();
        clear_logs();
        cfg_base = 32'h803;
        cfg_len  = 16'd1;
        send_sample(12'd1);
        send_sample(12'd2);
        for (int i = 0; i < 50 && wr_addr_q.size() < 2; i++) step();
        repeat (3) step();
        checks++; if (wr_addr_q.size() !== 2) begin failures++; $display("FAIL len1_count got=%0d exp=2", wr_addr_q.size()); end
        for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== 32'h800) begin failures++; $display("FAIL len1_addr%0d got=%h exp=800", i, wr_addr_q[i]); end
        end
        checks++; if (wrap_cnt !== 2) begin failures++; $display("FAIL len1_wrap got=%0d exp=2", wrap_cnt); end
        checks++; if (half_cnt !== 0) begin failures++; $display("FAIL len1_half got=%0d exp=0", half_cnt); end
        checks++; if (wr_index !== 16'd0) begin failures++; $display("FAIL len1_wr_index got=%0d exp=0", wr_index); end
    endtask

    task automatic test_back_to_back_words();
        logic [31:0] exp_d [3];
`ifdef ADC_DMA_TIMESTAMP_EN
        exp_d = '{32'h000007FF, 32'h000017FF, 32'h000027FF};
`else
        exp_d = '{32'h000007FF, 32'h000007FF, 32'h000007FF};
`endif
        cfg_base = 32'h400;
        cfg_len  = 16'd4;
        pulse_clear();
        clear_logs();
        for (int i = 0; i < 3; i++) send_sample(12'h7FF);
        for (int i = 0; i < 50 && wr_addr_q.size() < 3; i++) step();
        checks++; if (wr_addr_q.size() !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", wr_addr_q.size()); end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_data_q[i] !== exp_d[i] || wr_addr_q[i] !== 32'h400 + 32'(4 * i)) begin
                failures++; $display("FAIL b2b_word%0d got=%h/%h exp=%h/%h", i, wr_addr_q[i], wr_data_q[i], 32'h400 + 32'(4 * i), exp_d[i]);
            end
        end
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; cfg_en = 1'b0; cfg_clear = 1'b0; cfg_base = '0; cfg_len = '0;
        s_valid = 1'b0; s_data = '0; mem_ready = 1'b0;
        ready_delay = 1; wait_cnt = 0; ts_ctr = '0;
        clear_logs();
        test_reset();
        test_ring();
        test_fifth_sample();
        test_overflow();
        test_disable_in_req();
        test_len0_and_reset();
        test_len1();
        test_back_to_back_words();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
